// File: rtl/vproc_fpu_redseq.sv
// vproc_fpu_redseq
// Ordered floating-point reduction sequencer. It takes chunks of OP_W/ELEM_W
// elements with a per-element active mask and seeds the accumulator with a
// scalar on the first chunk. Active elements are folded strictly in index
// order through an external two-operand FU, one request in flight at a time.
//
// Ports
//   clk_i, sync_rst_i        clock, synchronous active-high reset
//   in_valid_i / in_ready_o  chunk handshake
//   in_first_i, in_last_i    reduction framing
//   in_init_i                scalar seed, used only with in_first_i
//   in_data_i, in_mask_i     packed elements and their active bits
//   fu_req_valid_o / fu_req_ready_i, fu_op_a_o, fu_op_b_o   FU request
//   fu_resp_valid_i, fu_res_i                                FU response
//   out_valid_o / out_ready_i, out_res_o, out_cnt_o          final result
//
// state | meaning
// IDLE  | waiting for a chunk
// ISSUE | presenting the lowest pending element to the FU
// WAIT  | one request outstanding, waiting for its result
// DONE  | presenting the final result

module vproc_fpu_redseq #(
    parameter int OP_W   = 64,
    parameter int ELEM_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic                     clk_i,
    input  logic                     sync_rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     in_first_i,
    input  logic                     in_last_i,
    input  logic [ELEM_W-1:0]        in_init_i,
    input  logic [OP_W-1:0]          in_data_i,
    input  logic [OP_W/ELEM_W-1:0]   in_mask_i,
    output logic                     fu_req_valid_o,
    input  logic                     fu_req_ready_i,
    output logic [ELEM_W-1:0]        fu_op_a_o,
    output logic [ELEM_W-1:0]        fu_op_b_o,
    input  logic                     fu_resp_valid_i,
    input  logic [ELEM_W-1:0]        fu_res_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [ELEM_W-1:0]        out_res_o,
    output logic [CNT_W-1:0]         out_cnt_o
);

    localparam int NE = OP_W / ELEM_W;
    localparam logic [NE-1:0]    ONE_NE  = NE'(1);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [OP_W-1:0]     data_q;
    logic [NE-1:0]       pend_q;
    logic                last_q;
    logic [ELEM_W-1:0]   acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ELEM_W-1:0]   sel_elem;

    // Lowest pending element; iterating downwards lets the lowest index win.
    always_comb begin
        sel_elem = '0;
        for (int k = NE - 1; k >= 0; k--) begin
            if (pend_q[k]) begin
                sel_elem = data_q[k*ELEM_W +: ELEM_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            state_q <= IDLE;
            data_q  <= '0;
            pend_q  <= '0;
            last_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        data_q <= in_data_i;
                        pend_q <= in_mask_i;
                        last_q <= in_last_i;
                        // A first chunk always restarts, dropping any open reduction.
                        if (in_first_i) begin
                            acc_q <= in_init_i;
                            cnt_q <= '0;
                        end
                        if (in_mask_i != '0) begin
                            state_q <= ISSUE;
                        end else if (in_last_i) begin
                            state_q <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    if (fu_req_ready_i) begin
                        // x & (x-1) clears the lowest set bit.
                        pend_q  <= pend_q & (pend_q - ONE_NE);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (fu_resp_valid_i) begin
                        acc_q <= fu_res_i;
                        if (cnt_q != '1) begin
                            cnt_q <= cnt_q + ONE_CNT;
                        end
                        if (pend_q != '0) begin
                            state_q <= ISSUE;
                        end else if (last_q) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; reset forces them all low at once.
    assign in_ready_o     = !sync_rst_i && (state_q == IDLE);
    assign fu_req_valid_o = !sync_rst_i && (state_q == ISSUE);
    assign out_valid_o    = !sync_rst_i && (state_q == DONE);
    assign fu_op_a_o      = sync_rst_i ? '0 : acc_q;
    assign fu_op_b_o      = sync_rst_i ? '0 : sel_elem;
    assign out_res_o      = sync_rst_i ? '0 : acc_q;
    assign out_cnt_o      = sync_rst_i ? '0 : cnt_q;

endmodule

// File: tb/tb_vproc_fpu_redseq.sv
module tb_vproc_fpu_redseq;

    logic        clk;
    logic        sync_rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_first;
    logic        in_last;
    logic [31:0] in_init;
    logic [63:0] in_data;
    logic [1:0]  in_mask;
    logic        fu_req_valid;
    logic        fu_req_ready;
    logic [31:0] fu_op_a;
    logic [31:0] fu_op_b;
    logic        fu_resp_valid;
    logic [31:0] fu_res;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic [7:0]  out_cnt;

    vproc_fpu_redseq #(.OP_W(64), .ELEM_W(32), .CNT_W(8)) dut (
        .clk_i          (clk),
        .sync_rst_i     (sync_rst),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_first_i     (in_first),
        .in_last_i      (in_last),
        .in_init_i      (in_init),
        .in_data_i      (in_data),
        .in_mask_i      (in_mask),
        .fu_req_valid_o (fu_req_valid),
        .fu_req_ready_i (fu_req_ready),
        .fu_op_a_o      (fu_op_a),
        .fu_op_b_o      (fu_op_b),
        .fu_resp_valid_i(fu_resp_valid),
        .fu_res_i       (fu_res),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_res_o      (out_res),
        .out_cnt_o      (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc_cyc = 0;
    logic stray = 1'b0;

    typedef struct { logic [31:0] a; logic [31:0] b; } req_t;
    typedef struct { logic [31:0] res; logic [7:0] cnt; } res_t;
    req_t req_q[$];
    res_t res_q[$];

    typedef struct {
        logic [31:0] init;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  mask;
        logic [31:0] exp_res;
        logic [7:0]  exp_cnt;
    } vec_t;
    vec_t vecs[5];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference fold: pushes the requests a chunk must produce, returns new acc.
    task automatic push_reqs(input logic [31:0] acc_in, input logic [31:0] e0,
                             input logic [31:0] e1, input logic [1:0] mask,
                             output logic [31:0] acc_out);
        logic [31:0] acc;
        logic [31:0] e;
        req_t r;
        acc = acc_in;
        for (int k = 0; k < 2; k++) begin
            e = (k == 0) ? e0 : e1;
            if (mask[k]) begin
                r.a = acc;
                r.b = e;
                req_q.push_back(r);
                acc = acc + e;
            end
        end
        acc_out = acc;
    endtask

    task automatic push_res(input logic [31:0] res, input logic [7:0] cnt);
        res_t r;
        r.res = res;
        r.cnt = cnt;
        res_q.push_back(r);
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send_chunk(input logic first, input logic last, input logic [31:0] init,
                              input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] mask);
        int n;
        in_valid = 1'b1;
        in_first = first;
        in_last  = last;
        in_init  = init;
        in_data  = {e1, e0};
        in_mask  = mask;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL chunk_accept_timeout: got no in_ready expected in_ready=1");
        end
        acc_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout: got out_valid=0 expected 1");
        end
        lat = cyc - acc_cyc;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got in_ready=0 expected 1");
        end
    endtask

    // Stub FU: integer adder, result valid 3 cycles after the request handshake.
    initial begin
        int cd;
        logic [31:0] sum;
        cd = 0;
        sum = '0;
        fu_resp_valid = 1'b0;
        fu_res = '0;
        forever begin
            @(negedge clk);
            #1;
            fu_resp_valid = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    fu_resp_valid = 1'b1;
                    fu_res = sum;
                end
            end
            if (stray) begin
                fu_resp_valid = 1'b1;
                fu_res = 32'hDEAD;
                stray = 1'b0;
            end
            if (fu_req_valid && fu_req_ready) begin
                cd = 3;
                sum = fu_op_a + fu_op_b;
            end
        end
    end

    // Scoreboard and handshake-stability monitor.
    initial begin
        logic        req_hold, out_hold;
        logic [31:0] pa, pb, pr;
        logic [7:0]  pc;
        req_t rq;
        res_t rs;
        req_hold = 1'b0;
        out_hold = 1'b0;
        pa = '0; pb = '0; pr = '0; pc = '0;
        forever begin
            @(negedge clk);
            #1;
            if (sync_rst) begin
                req_hold = 1'b0;
                out_hold = 1'b0;
            end else begin
                if (req_hold) begin
                    chk("req_hold_valid", fu_req_valid, 1'b1);
                    chk("req_hold_op_a", fu_op_a, pa);
                    chk("req_hold_op_b", fu_op_b, pb);
                end
                if (out_hold) begin
                    chk("out_hold_valid", out_valid, 1'b1);
                    chk("out_hold_res", out_res, pr);
                    chk("out_hold_cnt", out_cnt, pc);
                end
                if (fu_req_valid || out_valid) chk("in_ready_busy", in_ready, 1'b0);
                if (fu_req_valid && fu_req_ready) begin
                    if (req_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req: got a=%0h b=%0h expected no request", fu_op_a, fu_op_b);
                    end else begin
                        rq = req_q.pop_front();
                        chk("req_op_a", fu_op_a, rq.a);
                        chk("req_op_b", fu_op_b, rq.b);
                    end
                end
                if (out_valid && out_ready) begin
                    if (res_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got res=%0h expected no result", out_res);
                    end else begin
                        rs = res_q.pop_front();
                        chk("out_res", out_res, rs.res);
                        chk("out_cnt", out_cnt, rs.cnt);
                    end
                end
                req_hold = fu_req_valid && !fu_req_ready;
                out_hold = out_valid && !out_ready;
                pa = fu_op_a; pb = fu_op_b; pr = out_res; pc = out_cnt;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] acc;
        int lat;
        vecs[0] = '{32'd10,         32'd1,         32'd2, 2'b11, 32'd13,         8'd2};
        vecs[1] = '{32'd0,          32'd5,         32'd7, 2'b10, 32'd7,          8'd1};
        vecs[2] = '{32'd100,        32'd3,         32'd4, 2'b01, 32'd103,        8'd1};
        vecs[3] = '{32'h3F80_0000,  32'd9,         32'd9, 2'b00, 32'h3F80_0000,  8'd0};
        vecs[4] = '{32'd5,          32'hFFFF_FFFF, 32'd1, 2'b11, 32'd5,          8'd2};

        sync_rst = 1'b1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_init = '0; in_data = '0; in_mask = '0;
        fu_req_ready = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_req_valid", fu_req_valid, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_res", out_res, 32'd0);
        sync_rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Single first+last chunks.
        for (int i = 0; i < 5; i++) begin
            push_reqs(vecs[i].init, vecs[i].e0, vecs[i].e1, vecs[i].mask, acc);
            push_res(vecs[i].exp_res, vecs[i].exp_cnt);
            send_chunk(1'b1, 1'b1, vecs[i].init, vecs[i].e0, vecs[i].e1, vecs[i].mask);
            chk("first_req_cycle", fu_req_valid, vecs[i].mask != 2'b00);
            wait_out(lat);
            chk("out_latency", lat, 1 + 4 * $countones(vecs[i].mask));
            @(negedge clk);
        end

        // Masking across two chunks.
        push_reqs(32'd0, 32'd5, 32'd7, 2'b10, acc);
        push_reqs(acc, 32'd3, 32'd4, 2'b01, acc);
        push_res(acc, 8'd2);
        send_chunk(1'b1, 1'b0, 32'd0, 32'd5, 32'd7, 2'b10);
        send_chunk(1'b0, 1'b1, 32'd99, 32'd3, 32'd4, 2'b01);
        wait_out(lat);
        @(negedge clk);

        // Backpressure on both the FU request and the result.
        fu_req_ready = 1'b0;
        out_ready = 1'b0;
        push_reqs(32'd1, 32'd2, 32'd3, 2'b11, acc);
        push_res(32'd6, 8'd2);
        send_chunk(1'b1, 1'b1, 32'd1, 32'd2, 32'd3, 2'b11);
        for (int i = 0; i < 4; i++) begin
            chk("bp_req_valid", fu_req_valid, 1'b1);
            chk("bp_req_a", fu_op_a, 32'd1);
            chk("bp_req_b", fu_op_b, 32'd2);
            @(negedge clk);
        end
        fu_req_ready = 1'b1;
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_out_res", out_res, 32'd6);
            chk("bp_in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);

        // Restart mid-reduction, stray responses in IDLE.
        push_reqs(32'd50, 32'd1, 32'd0, 2'b01, acc);
        send_chunk(1'b1, 1'b0, 32'd50, 32'd1, 32'd0, 2'b01);
        wait_idle();
        stray = 1'b1;
        repeat (2) @(negedge clk);
        push_reqs(32'd200, 32'd9, 32'd0, 2'b01, acc);
        push_res(32'd209, 8'd1);
        send_chunk(1'b1, 1'b1, 32'd200, 32'd9, 32'd0, 2'b01);
        wait_out(lat);
        @(negedge clk);

        push_reqs(32'd30, 32'd2, 32'd0, 2'b01, acc);
        send_chunk(1'b1, 1'b0, 32'd30, 32'd2, 32'd0, 2'b01);
        wait_idle();
        stray = 1'b1;
        repeat (2) @(negedge clk);
        push_res(32'd32, 8'd1);
        send_chunk(1'b0, 1'b1, 32'd77, 32'd0, 32'd0, 2'b00);
        wait_out(lat);
        chk("stray_empty_latency", lat, 1);
        @(negedge clk);

        // Reset while a request is outstanding.
        push_reqs(32'd7, 32'd1, 32'd0, 2'b01, acc);
        send_chunk(1'b1, 1'b1, 32'd7, 32'd1, 32'd0, 2'b01);
        @(negedge clk);
        sync_rst = 1'b1;
        #1;
        chk("wrst_in_ready", in_ready, 1'b0);
        chk("wrst_req_valid", fu_req_valid, 1'b0);
        chk("wrst_out_valid", out_valid, 1'b0);
        chk("wrst_op_a", fu_op_a, 32'd0);
        chk("wrst_op_b", fu_op_b, 32'd0);
        chk("wrst_out_res", out_res, 32'd0);
        chk("wrst_out_cnt", out_cnt, 8'd0);
        @(negedge clk);
        sync_rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("late_resp_in_ready", in_ready, 1'b1);
        chk("late_resp_out_valid", out_valid, 1'b0);
        chk("late_resp_req_valid", fu_req_valid, 1'b0);
        push_reqs(32'd20, 32'd4, 32'd5, 2'b11, acc);
        push_res(32'd29, 8'd2);
        send_chunk(1'b1, 1'b1, 32'd20, 32'd4, 32'd5, 2'b11);
        wait_out(lat);
        chk("post_wrst_latency", lat, 9);
        repeat (2) @(negedge clk);

        chk("req_queue_drained", req_q.size(), 0);
        chk("res_queue_drained", res_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
